// File: rtl/risc_ctrl_pkg.sv
// Shared encodings for the RISC datapath controller: states, ALU ops, register selects,
// writeback selects, instruction fields, and the instruction-class decode.
package risc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_GET_A     = 3'd2,
    S_GET_B     = 3'd3,
    S_EXEC      = 3'd4,
    S_WRITE_REG = 3'd5,
    S_WRITE_IMM = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_MOVIMM,
    C_MOVREG,
    C_MVN,
    C_ADD,
    C_CMP,
    C_AND,
    C_ILLEGAL
  } iclass_t;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_AND  = 2'b10;
  localparam logic [1:0] ALUOP_NOTB = 2'b11;

  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b001;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b100;

  localparam logic [1:0] VSEL_C   = 2'b00;
  localparam logic [1:0] VSEL_IMM = 2'b01;

  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_ALU    = 3'b101;
  localparam logic [1:0] OP_MOVIMM  = 2'b10;
  localparam logic [1:0] OP_MOVREG  = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  function automatic iclass_t decode_class(input logic [2:0] opcode, input logic [1:0] op);
    iclass_t c;
    c = C_ILLEGAL;
    if (opcode == OPC_MOV && op == OP_MOVIMM)      c = C_MOVIMM;
    else if (opcode == OPC_MOV && op == OP_MOVREG) c = C_MOVREG;
    else if (opcode == OPC_ALU) begin
      case (op)
        OP_ADD:  c = C_ADD;
        OP_CMP:  c = C_CMP;
        OP_AND:  c = C_AND;
        default: c = C_MVN;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/datapath_ctrl_fsm.sv
// Moore sequencer driving regfile/A/B/C/status loads and ALUop for one latched instruction;
// s is taken only while w=1, and an instruction runs 1-5 cycles before WAIT returns.
module datapath_ctrl_fsm
  import risc_ctrl_pkg::*;
#(
  parameter int NSEL_W = 3,
  parameter int VSEL_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s,
  input  logic [2:0]        opcode,
  input  logic [1:0]        op,
  output logic              w,
  output logic [NSEL_W-1:0] nsel,
  output logic [VSEL_W-1:0] vsel,
  output logic              loada,
  output logic              loadb,
  output logic              asel,
  output logic              bsel,
  output logic [1:0]        ALUop,
  output logic              loadc,
  output logic              loads,
  output logic              write,
  output logic              illegal
);

  state_t     state;
  state_t     state_next;
  logic [4:0] instr_q;
  iclass_t    cls;

  assign cls = decode_class(instr_q[4:2], instr_q[1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_WAIT;
      instr_q <= '0;
    end else begin
      state <= state_next;
      if (state == S_WAIT && s) instr_q <= {opcode, op};
    end
  end

  always_comb begin
    state_next = S_WAIT;
    case (state)
      S_WAIT:   state_next = s ? S_DECODE : S_WAIT;
      S_DECODE: begin
        case (cls)
          C_MOVIMM:                 state_next = S_WRITE_IMM;
          C_MOVREG, C_MVN:          state_next = S_GET_B;
          C_ADD, C_CMP, C_AND:      state_next = S_GET_A;
          default:                  state_next = S_WAIT;
        endcase
      end
      S_GET_A:     state_next = S_GET_B;
      S_GET_B:     state_next = S_EXEC;
      S_EXEC:      state_next = (cls == C_CMP) ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_next = S_WAIT;
      S_WRITE_IMM: state_next = S_WAIT;
      // unused encoding falls back to idle
      default:     state_next = S_WAIT;
    endcase
  end

  always_comb begin
    w       = 1'b0;
    nsel    = NSEL_NONE;
    vsel    = VSEL_C;
    loada   = 1'b0;
    loadb   = 1'b0;
    asel    = 1'b0;
    bsel    = 1'b0;
    ALUop   = ALUOP_ADD;
    loadc   = 1'b0;
    loads   = 1'b0;
    write   = 1'b0;
    illegal = 1'b0;
    case (state)
      S_WAIT:   w = 1'b1;
      S_DECODE: illegal = (cls == C_ILLEGAL);
      S_GET_A: begin
        nsel  = NSEL_RN;
        loada = 1'b1;
      end
      S_GET_B: begin
        nsel  = NSEL_RM;
        loadb = 1'b1;
      end
      S_EXEC: begin
        ALUop = (instr_q[4:2] == OPC_ALU) ? instr_q[1:0] : ALUOP_ADD;
        asel  = (cls == C_MOVREG);
        loads = (cls == C_CMP);
        loadc = (cls != C_CMP);
      end
      S_WRITE_REG: begin
        nsel  = NSEL_RD;
        vsel  = VSEL_C;
        write = 1'b1;
      end
      S_WRITE_IMM: begin
        nsel  = NSEL_RN;
        vsel  = VSEL_IMM;
        write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_datapath_ctrl_fsm.sv
// Randomized bench for datapath_ctrl_fsm against a per-instruction step-list model.
module tb_datapath_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w, loada, loadb, asel, bsel, loadc, loads, write, illegal;
  logic [2:0] nsel;
  logic [1:0] vsel, ALUop;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  logic [15:0] wait_vec;
  logic        timed_out;

  localparam logic [4:0] I_MOVIMM = 5'b110_10;
  localparam logic [4:0] I_MOVREG = 5'b110_00;
  localparam logic [4:0] I_MVN    = 5'b101_11;
  localparam logic [4:0] I_ADD    = 5'b101_00;
  localparam logic [4:0] I_CMP    = 5'b101_01;
  localparam logic [4:0] I_AND    = 5'b101_10;

  datapath_ctrl_fsm #(.NSEL_W(3), .VSEL_W(2)) dut (
    .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
    .w(w), .nsel(nsel), .vsel(vsel), .loada(loada), .loadb(loadb),
    .asel(asel), .bsel(bsel), .ALUop(ALUop), .loadc(loadc), .loads(loads),
    .write(write), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // {w, nsel, vsel, loada, loadb, asel, bsel, ALUop, loadc, loads, write, illegal}
  function automatic logic [15:0] cur_vec();
    return {w, nsel, vsel, loada, loadb, asel, bsel, ALUop, loadc, loads, write, illegal};
  endfunction

  function automatic logic [15:0] mk(input logic [2:0] ns, input logic [1:0] vs,
                                     input logic la, input logic lb, input logic as,
                                     input logic [1:0] alu, input logic lc, input logic ls,
                                     input logic wr, input logic il);
    return {1'b0, ns, vs, la, lb, as, 1'b0, alu, lc, ls, wr, il};
  endfunction

  localparam logic [15:0] IDLE = 16'h8000;

  // Expected cycles after accept, up to (not including) the return to WAIT.
  function automatic void model(input logic [4:0] ins);
    logic [15:0] decode_step, read_rn, read_rm, wr_c, wr_imm;
    decode_step = mk(3'b000, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    read_rn     = mk(3'b001, 2'b00, 1, 0, 0, 2'b00, 0, 0, 0, 0);
    read_rm     = mk(3'b100, 2'b00, 0, 1, 0, 2'b00, 0, 0, 0, 0);
    wr_c        = mk(3'b010, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1, 0);
    wr_imm      = mk(3'b001, 2'b01, 0, 0, 0, 2'b00, 0, 0, 1, 0);
    exp_q.delete();
    if (ins == I_MOVIMM) begin
      exp_q = '{decode_step, wr_imm};
    end else if (ins == I_MOVREG) begin
      exp_q = '{decode_step, read_rm, mk(3'b000, 2'b00, 0, 0, 1, 2'b00, 1, 0, 0, 0), wr_c};
    end else if (ins == I_MVN) begin
      exp_q = '{decode_step, read_rm, mk(3'b000, 2'b00, 0, 0, 0, 2'b11, 1, 0, 0, 0), wr_c};
    end else if (ins == I_CMP) begin
      exp_q = '{decode_step, read_rn, read_rm, mk(3'b000, 2'b00, 0, 0, 0, 2'b01, 0, 1, 0, 0)};
    end else if (ins == I_ADD || ins == I_AND) begin
      exp_q = '{decode_step, read_rn, read_rm, mk(3'b000, 2'b00, 0, 0, 0, ins[1:0], 1, 0, 0, 0), wr_c};
    end else begin
      exp_q = '{mk(3'b000, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 1)};
    end
  endfunction

  // Issue one instruction from a WAIT negedge; capture every busy cycle and the WAIT that follows.
  task automatic run_instr(input logic [4:0] ins, input logic hold_s);
    int guard;
    s = 1'b1; opcode = ins[4:2]; op = ins[1:0];
    @(posedge clk);
    @(negedge clk);
    s = hold_s;
    obs_q.delete();
    guard = 0;
    while (!w && guard < 12) begin
      obs_q.push_back(cur_vec());
      opcode = 3'($urandom);
      op     = 2'($urandom);
      @(negedge clk);
      guard++;
    end
    timed_out = !w;
    wait_vec  = cur_vec();
  endtask

  task automatic test_reset();
    reset = 1'b1; s = 1'b0; opcode = 3'b000; op = 2'b00;
    #13;
    n_assert++;
    if (cur_vec() !== IDLE) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want %h", cur_vec(), IDLE);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_assert++;
    if (cur_vec() !== IDLE) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %h want %h", cur_vec(), IDLE);
    end
  endtask

  task automatic test_mov_imm();
    model(I_MOVIMM);
    run_instr(I_MOVIMM, 1'b0);
    n_assert++;
    if (timed_out || obs_q.size() !== 2) begin
      n_fail++;
      $display("FAIL movimm_latency: got %0d busy cycles want 2", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_assert++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL movimm_step%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_assert++;
    if (obs_q.size() < 2 || obs_q[1][14:12] !== 3'b001 || obs_q[1][11:10] !== 2'b01 || obs_q[1][1] !== 1'b1) begin
      n_fail++;
      $display("FAIL movimm_write_fields: got %h want nsel=001 vsel=01 write=1", obs_q.size() > 1 ? obs_q[1] : 16'hxxxx);
    end
  endtask

  task automatic test_alu_class(input logic [4:0] ins, input string name);
    model(ins);
    run_instr(ins, 1'b0);
    n_assert++;
    if (timed_out || obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d busy cycles want %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_assert++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s_step%0d: got %h want %h", name, i, obs_q[i], exp_q[i]);
      end
    end
    n_assert++;
    if (wait_vec !== IDLE) begin
      n_fail++;
      $display("FAIL %s_wait: got %h want %h", name, wait_vec, IDLE);
    end
  endtask

  task automatic test_illegal();
    int pulses;
    model(5'b111_00);
    run_instr(5'b111_00, 1'b0);
    pulses = 0;
    foreach (obs_q[i]) pulses += int'(obs_q[i][0]);
    n_assert++;
    if (pulses !== 1 || obs_q.size() !== 1 || obs_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL illegal_pulse: got %0d pulses over %0d cycles want 1 over 1", pulses, obs_q.size());
    end
  endtask

  task automatic test_reset_abort();
    logic bad;
    s = 1'b1; opcode = I_ADD[4:2]; op = I_ADD[1:0];
    @(posedge clk);
    @(negedge clk);
    s = 1'b0;
    repeat (2) @(negedge clk);
    n_assert++;
    if (loadb !== 1'b1 || nsel !== 3'b100) begin
      n_fail++;
      $display("FAIL abort_in_get_b: got loadb=%b nsel=%b want 1/100", loadb, nsel);
    end
    #1 reset = 1'b1;
    #1;
    n_assert++;
    if (w !== 1'b1 || loadb !== 1'b0 || write !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_immediate: got w=%b loadb=%b write=%b want 1/0/0", w, loadb, write);
    end
    @(negedge clk);
    reset = 1'b0;
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (write !== 1'b0 || loads !== 1'b0 || w !== 1'b1) bad = 1'b1;
    end
    n_assert++;
    if (bad) begin
      n_fail++;
      $display("FAIL abort_no_writeback: got activity after reset want idle");
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] table_i[6] = '{I_MOVIMM, I_MOVREG, I_MVN, I_ADD, I_CMP, I_AND};
    logic [4:0] ins;
    logic       hold;
    for (int k = 0; k < 40; k++) begin
      ins  = ($urandom_range(0, 4) == 0) ? 5'($urandom) : table_i[$urandom_range(0, 5)];
      hold = 1'($urandom);
      model(ins);
      run_instr(ins, hold);
      n_assert++;
      if (timed_out || obs_q.size() !== exp_q.size()) begin
        n_fail++;
        $display("FAIL b2b%0d_latency ins=%b: got %0d want %0d", k, ins, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_assert++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL b2b%0d_step%0d ins=%b: got %h want %h", k, i, ins, obs_q[i], exp_q[i]);
        end
      end
      n_assert++;
      if (wait_vec !== IDLE) begin
        n_fail++;
        $display("FAIL b2b%0d_wait: got %h want %h", k, wait_vec, IDLE);
      end
    end
    s = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mov_imm();
    test_alu_class(I_ADD, "add");
    test_alu_class(I_CMP, "cmp");
    test_alu_class(I_MOVREG, "movreg");
    test_alu_class(I_MVN, "mvn");
    test_alu_class(I_AND, "and");
    test_illegal();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want completion");
    $fatal(1);
  end

endmodule
